// File: rtl/uart_rx_param_if.sv
// Ready/valid receive-character channel between the UART receiver and its consumer.
interface uart_rx_param_if #(
  parameter int DataBits = 8
);
  logic [DataBits-1:0] DataOut;
  logic                DataOutValid;
  logic                DataOutReady;
  logic                ParityErrorOut;
  logic                FrameErrorOut;

  modport master (
    output DataOut, DataOutValid, ParityErrorOut, FrameErrorOut,
    input  DataOutReady
  );

  modport slave (
    input  DataOut, DataOutValid, ParityErrorOut, FrameErrorOut,
    output DataOutReady
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote,
// parity/framing checks and a first-word-fall-through receive FIFO.
//
// state     | meaning
// IDLE      | line idle, waiting for SSync low
// START     | validating start bit (false start returns to IDLE)
// DATA      | shifting in DataBits bits, LSB first
// PARITY    | checking the parity bit
// STOP      | checking StopBits stop bits, push at last resolve point
// WAIT_HIGH | framing error seen, wait for the line to return high
module uart_rx_param #(
  parameter int ClockFreq = 100_000_000,
  parameter int BaudRate  = 115_200,
  parameter int DataBits  = 8,
  parameter int Parity    = 0,
  parameter int StopBits  = 1,
  parameter int FifoDepth = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             SIn,
  uart_rx_param_if.master  rx,
  output logic             Overrun,
  input  logic             OverrunClear
);

  localparam int SymbolEdgeTime = ClockFreq / BaudRate;
  localparam int SampleTime     = SymbolEdgeTime / 2;
  localparam int CntW           = $clog2(SymbolEdgeTime);
  localparam int AddrW          = $clog2(FifoDepth);
  localparam int EntryW         = DataBits + 2;

  localparam logic [CntW-1:0] CntEdge = CntW'(SymbolEdgeTime - 1);
  localparam logic [CntW-1:0] CntS0   = CntW'(SampleTime - 1);
  localparam logic [CntW-1:0] CntS1   = CntW'(SampleTime);
  localparam logic [CntW-1:0] CntS2   = CntW'(SampleTime + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

  logic                s_meta, s_sync;
  logic [2:0]          state;
  logic [CntW-1:0]     clk_cnt;
  logic [1:0]          samples;
  logic [3:0]          bit_cnt;
  logic                stop_cnt;
  logic [DataBits-1:0] shreg;
  logic                pe, fe;
  logic                voted, at_edge, resolve, last_stop;
  logic                push, pop, push_ok, full, empty;
  logic [EntryW-1:0]   push_entry, head;
  logic [EntryW-1:0]   mem [FifoDepth];
  logic [AddrW-1:0]    wptr, rptr;
  logic [AddrW:0]      count;

  // Synchroniser resets to idle-high so reset release never looks like a start bit.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      s_meta <= 1'b1;
      s_sync <= 1'b1;
    end else begin
      s_meta <= SIn;
      s_sync <= s_meta;
    end
  end

  assign at_edge   = (clk_cnt == CntEdge);
  assign resolve   = (clk_cnt == CntS2);
  assign voted     = (samples[0] & samples[1]) | (samples[0] & s_sync) | (samples[1] & s_sync);
  assign last_stop = (stop_cnt == 1'(StopBits - 1));
  assign push      = (state == STOP) && resolve && last_stop;
  assign push_entry = {pe, fe | ~voted, shreg};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      samples  <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      pe       <= 1'b0;
      fe       <= 1'b0;
    end else begin
      if (state == IDLE || state == WAIT_HIGH || at_edge) clk_cnt <= '0;
      else clk_cnt <= clk_cnt + 1'b1;
      if (clk_cnt == CntS0) samples[0] <= s_sync;
      if (clk_cnt == CntS1) samples[1] <= s_sync;

      case (state)
        IDLE: begin
          if (!s_sync) begin
            state    <= START;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            pe       <= 1'b0;
            fe       <= 1'b0;
          end
        end
        START: begin
          if (resolve && voted) state <= IDLE;
          else if (at_edge) state <= DATA;
        end
        DATA: begin
          if (resolve) begin
            shreg   <= {voted, shreg[DataBits-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (at_edge && bit_cnt == 4'(DataBits)) state <= (Parity != 0) ? PARITY : STOP;
        end
        PARITY: begin
          // Odd mode flags an even total of ones, even mode flags an odd total.
          if (resolve) pe <= (Parity == 1) ? ~(^shreg ^ voted) : (^shreg ^ voted);
          if (at_edge) state <= STOP;
        end
        STOP: begin
          if (resolve) begin
            if (!voted) fe <= 1'b1;
            if (last_stop) state <= (fe | ~voted) ? WAIT_HIGH : IDLE;
            else stop_cnt <= stop_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (s_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == (AddrW+1)'(FifoDepth));
  assign pop     = !empty && rx.DataOutReady;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge Clock) begin
    if (push_ok) mem[wptr] <= push_entry;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      Overrun <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) Overrun <= 1'b1;
      else if (OverrunClear) Overrun <= 1'b0;
    end
  end

  assign head              = mem[rptr];
  assign rx.DataOut        = head[DataBits-1:0];
  assign rx.DataOutValid   = !empty;
  assign rx.ParityErrorOut = !empty && head[EntryW-1];
  assign rx.FrameErrorOut  = !empty && head[DataBits];

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and a 7E1 instance at 10 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_param;
  localparam int Cf  = 1_000_000;
  localparam int Br  = 100_000;
  localparam int Bit = 10;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic sin8 = 1'b1, sin7 = 1'b1;
  logic ovc8 = 1'b0, ovc7 = 1'b0;
  logic ov8, ov7;
  logic rdy8 = 1'b0, rdy7 = 1'b0, rnd_rdy = 1'b0;
  bit   rand_ready = 1'b0;

  uart_rx_param_if #(.DataBits(8)) rx8 ();
  uart_rx_param_if #(.DataBits(7)) rx7 ();

  assign rx8.DataOutReady = rand_ready ? rnd_rdy : rdy8;
  assign rx7.DataOutReady = rdy7;

  uart_rx_param #(.ClockFreq(Cf), .BaudRate(Br), .DataBits(8), .Parity(0),
                  .StopBits(1), .FifoDepth(4)) u8 (
    .Clock(Clock), .Reset(Reset), .SIn(sin8), .rx(rx8),
    .Overrun(ov8), .OverrunClear(ovc8));

  uart_rx_param #(.ClockFreq(Cf), .BaudRate(Br), .DataBits(7), .Parity(2),
                  .StopBits(1), .FifoDepth(4)) u7 (
    .Clock(Clock), .Reset(Reset), .SIn(sin7), .rx(rx7),
    .Overrun(ov7), .OverrunClear(ovc7));

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] data;
    logic       parb;
    logic       stopb;
    logic [6:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec7_t;

  vec7_t tab [7];

  logic [9:0] got8 [$];
  logic [9:0] exp8 [$];
  int valid_cycles8 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  always @(negedge Clock) begin
    if (!Reset && rx8.DataOutValid) begin
      valid_cycles8++;
      if (rx8.DataOutReady) got8.push_back({rx8.ParityErrorOut, rx8.FrameErrorOut, rx8.DataOut});
    end
  end

  always @(posedge Clock) begin
    #2;
    if (rand_ready) rnd_rdy = 1'($urandom_range(0, 1));
  end

  task automatic drive_bit(input int line, input logic b);
    if (line == 8) sin8 = b;
    else sin7 = b;
    repeat (Bit) tick();
  endtask

  task automatic send_frame(input int line, input logic [8:0] d, input int nbits,
                            input bit has_par, input logic parb, input logic stopb);
    drive_bit(line, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(line, d[i]);
    if (has_par) drive_bit(line, parb);
    drive_bit(line, stopb);
    if (line == 8) sin8 = 1'b1;
    else sin7 = 1'b1;
  endtask

  // 8N1 reference: no parity flag, framing error exactly when the stop bit is low.
  task automatic expect8(input logic [7:0] d, input logic stopb);
    exp8.push_back({1'b0, ~stopb, d});
  endtask

  task automatic compare_q8(input string name);
    check({name, "_count"}, got8.size(), exp8.size());
    for (int i = 0; i < exp8.size() && i < got8.size(); i++)
      check($sformatf("%s_entry%0d", name, i), got8[i], exp8[i]);
    got8.delete();
    exp8.delete();
  endtask

  task automatic apply7(input string name, input logic [6:0] d, input logic parb, input logic stopb,
                        input logic [6:0] ed, input logic epe, input logic efe);
    int w;
    rdy7 = 1'b0;
    send_frame(7, {2'b00, d}, 7, 1'b1, parb, stopb);
    w = 0;
    while (!rx7.DataOutValid && w < 50) begin
      tick();
      w++;
    end
    check({name, "_valid"}, rx7.DataOutValid, 1'b1);
    check({name, "_data"}, rx7.DataOut, ed);
    check({name, "_pe"}, rx7.ParityErrorOut, epe);
    check({name, "_fe"}, rx7.FrameErrorOut, efe);
    rdy7 = 1'b1;
    tick();
    rdy7 = 1'b0;
    check({name, "_popped"}, rx7.DataOutValid, 1'b0);
    repeat (15) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    logic [7:0] d8;
    logic sb;
    logic [6:0] d7;
    logic pb;

    tab[0] = '{7'h03, 1'b0, 1'b1, 7'h03, 1'b0, 1'b0};
    tab[1] = '{7'h03, 1'b1, 1'b1, 7'h03, 1'b1, 1'b0};
    tab[2] = '{7'h7F, 1'b1, 1'b1, 7'h7F, 1'b0, 1'b0};
    tab[3] = '{7'h00, 1'b1, 1'b1, 7'h00, 1'b1, 1'b0};
    tab[4] = '{7'h55, 1'b0, 1'b1, 7'h55, 1'b0, 1'b0};
    tab[5] = '{7'h2A, 1'b0, 1'b1, 7'h2A, 1'b1, 1'b0};
    tab[6] = '{7'h40, 1'b1, 1'b0, 7'h40, 1'b0, 1'b1};

    repeat (3) tick();
    Reset = 1'b0;
    tick();
    check("rst_valid8", rx8.DataOutValid, 1'b0);
    check("rst_overrun8", ov8, 1'b0);
    check("rst_pe8", rx8.ParityErrorOut, 1'b0);
    check("rst_fe8", rx8.FrameErrorOut, 1'b0);
    check("rst_valid7", rx7.DataOutValid, 1'b0);
    check("rst_overrun7", ov7, 1'b0);

    // Single 8N1 character with the consumer always ready.
    rdy8 = 1'b1;
    v0 = valid_cycles8;
    send_frame(8, 9'h0A5, 8, 1'b0, 1'b0, 1'b1);
    expect8(8'hA5, 1'b1);
    repeat (20) tick();
    check("a5_valid_cycles", valid_cycles8 - v0, 1);
    compare_q8("a5");
    check("a5_overrun", ov8, 1'b0);

    // Break: bad stop bit then line held low for 30 bit times.
    send_frame(8, 9'h055, 8, 1'b0, 1'b0, 1'b0);
    sin8 = 1'b0;
    expect8(8'h55, 1'b0);
    repeat (30 * Bit) tick();
    compare_q8("break");
    sin8 = 1'b1;
    repeat (20) tick();
    compare_q8("break_release");
    send_frame(8, 9'h03C, 8, 1'b0, 1'b0, 1'b1);
    expect8(8'h3C, 1'b1);
    repeat (20) tick();
    compare_q8("after_break");

    // Short glitch is a false start.
    sin8 = 1'b0;
    repeat (3) tick();
    sin8 = 1'b1;
    repeat (30) tick();
    compare_q8("glitch");
    send_frame(8, 9'h00F, 8, 1'b0, 1'b0, 1'b1);
    expect8(8'h0F, 1'b1);
    repeat (20) tick();
    compare_q8("after_glitch");

    // Overrun with the consumer stalled.
    rdy8 = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8, 9'(8'h11 * i), 8, 1'b0, 1'b0, 1'b1);
    repeat (20) tick();
    check("ovr_flag", ov8, 1'b1);
    check("ovr_valid", rx8.DataOutValid, 1'b1);
    check("ovr_head", rx8.DataOut, 8'h11);
    rdy8 = 1'b1;
    for (int i = 1; i <= 4; i++) expect8(8'(8'h11 * i), 1'b1);
    repeat (10) tick();
    compare_q8("ovr_drain");
    check("ovr_empty", rx8.DataOutValid, 1'b0);
    check("ovr_sticky", ov8, 1'b1);
    ovc8 = 1'b1;
    tick();
    ovc8 = 1'b0;
    check("ovr_cleared", ov8, 1'b0);

    // Reset pulse during data bit 3 of 0x81.
    sin8 = 1'b0;
    repeat (Bit) tick();
    sin8 = 1'b1;
    repeat (Bit) tick();
    sin8 = 1'b0;
    repeat (2 * Bit) tick();
    repeat (5) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    sin8 = 1'b1;
    repeat (15 * Bit) tick();
    check("midrst_valid", rx8.DataOutValid, 1'b0);
    compare_q8("midrst");
    send_frame(8, 9'h03C, 8, 1'b0, 1'b0, 1'b1);
    expect8(8'h3C, 1'b1);
    repeat (20) tick();
    compare_q8("after_midrst");

    // Randomised 8N1 traffic against the reference queue, random consumer stalls.
    rand_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      d8 = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      send_frame(8, {1'b0, d8}, 8, 1'b0, 1'b0, sb);
      expect8(d8, sb);
      repeat (sb ? $urandom_range(0, 12) : $urandom_range(5, 12)) tick();
    end
    rand_ready = 1'b0;
    rdy8 = 1'b1;
    repeat (30) tick();
    compare_q8("random8");
    check("random8_overrun", ov8, 1'b0);

    // 7E1 table vectors.
    for (int i = 0; i < 7; i++)
      apply7($sformatf("tab%0d", i), tab[i].data, tab[i].parb, tab[i].stopb,
             tab[i].exp_data, tab[i].exp_pe, tab[i].exp_fe);

    // Randomised 7E1: even mode flags an odd total of ones over data plus parity.
    for (int n = 0; n < 10; n++) begin
      d7 = 7'($urandom);
      pb = 1'($urandom_range(0, 1));
      apply7($sformatf("rnd7_%0d", n), d7, pb, 1'b1, d7,
             1'((($countones(d7) + int'(pb)) % 2) == 1), 1'b0);
    end
    check("final_overrun7", ov7, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, next generation of the lab serial receive path.
- Configurable data width, parity mode and stop-bit count.
- Metastability synchroniser and 3-sample majority vote on every bit.
- Per-character parity and framing error flags.
- Small first-word-fall-through receive FIFO with sticky overrun flag.
- Sits between the board serial pin and the ready/valid consumer (memory-mapped UART or CPU I/O).

Parameters:
ClockFreq, 100_000_000, system clock frequency in Hz
BaudRate, 115_200, line rate in bits/s; SymbolEdgeTime = ClockFreq/BaudRate, must be >= 8
DataBits, 8, data bits per character, legal range 5..9
Parity, 0, parity mode: 0 none, 1 odd, 2 even
StopBits, 1, stop bits checked, 1 or 2
FifoDepth, 4, receive FIFO entries, power of two >= 2

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
SIn  input  1  asynchronous serial line, idle high
DataOut  output  DataBits  data of FIFO head character, LSB = first received bit
DataOutValid  output  1  FIFO non-empty
DataOutReady  input  1  consumer accepts head when high with DataOutValid
ParityErrorOut  output  1  parity error flag of head entry (0 when Parity=0)
FrameErrorOut  output  1  framing error flag of head entry
Overrun  output  1  sticky: a character was dropped because the FIFO was full
OverrunClear  input  1  one-cycle pulse clears Overrun

Behaviour:
- SIn passes through a 2-flop synchroniser to give SSync; all decisions use SSync.
- ClockCounter width is ceil(log2(SymbolEdgeTime)). Counter restarts at 0 on start detect and at SymbolEdgeTime-1. SampleTime = SymbolEdgeTime/2.
- Bit value = majority of SSync at counts SampleTime-1, SampleTime and SampleTime+1, resolved at SampleTime+1.
- State machine:
  - IDLE: SSync low -> START, counter cleared.
  - START: voted bit 1 -> IDLE (false start, nothing pushed). Voted bit 0 -> DATA at symbol edge.
  - DATA: DataBits bits shifted in LSB-first, then go to PARITY if Parity != 0, else STOP.
  - PARITY: received parity bit checked. Odd mode: ones count (data + parity) must be odd. Even mode: must be even. Mismatch sets the pe flag.
  - STOP: StopBits stop bits are checked; any voted 0 sets the fe flag.
  - Push happens at the resolve point (SampleTime+1) of the last stop bit.
  - After the push: fe = 0 -> IDLE; fe = 1 -> WAIT_HIGH.
  - WAIT_HIGH: stay until SSync is high, then go to IDLE. This stops a held-low break from generating repeated frames.
- Latency: the pushed character is visible on DataOut/DataOutValid the cycle after the push cycle.
- FIFO:
  - Entry = {pe, fe, data}, FifoDepth entries, pointers wrap modulo FifoDepth.
  - Pop when DataOutValid && DataOutReady. DataOut and the flags always show the head entry and are held stable while Valid && !Ready.
  - Push while full with no pop in the same cycle: new character dropped, FIFO unchanged, Overrun set.
  - Push and pop in the same cycle while full: both take effect, no overrun.
  - Push and pop in the same cycle while empty: push takes effect, pop ignored (Valid was 0).
  - Overrun set and OverrunClear in the same cycle: set wins.
- Reset, including mid-frame:
  - State -> IDLE; FIFO empty; DataOutValid = 0; Overrun = 0; ParityErrorOut = 0; FrameErrorOut = 0; counters = 0.
  - Any partial character is discarded.
  - DataOut holds an undefined value while Valid = 0.
  - The synchroniser resets to 1 (idle), so releasing reset with the line idle causes no false start.

Test Plan:
All tests use ClockFreq=1_000_000, BaudRate=100_000 (10 clocks/bit) unless noted.
- 8N1, send 0xA5 with DataOutReady=1 -> one Valid cycle with DataOut=0xA5, ParityErrorOut=0, FrameErrorOut=0, Overrun=0.
- DataBits=7, Parity=2 (even): send 0x03 with parity bit 0 -> DataOut=0x03, ParityErrorOut=0. Same data with parity bit 1 -> ParityErrorOut=1.
- 8N1, send 0x55 with stop bit low, then hold SIn low for 30 bit times -> exactly one entry: 0x55 with FrameErrorOut=1. No further entries until SIn returns high and a new start bit arrives.
- SIn pulsed low for 3 clocks, then high -> no entry pushed, state back in IDLE. Following frame 0x0F received correctly.
- DataOutReady=0, send 0x11,0x22,0x33,0x44,0x55 (FifoDepth=4) -> Overrun=1. Popping yields 0x11,0x22,0x33,0x44, then Valid=0. OverrunClear pulse -> Overrun=0.
- Reset asserted for 1 cycle during data bit 3 of 0x81 -> Valid=0, no entry. Next complete frame 0x3C -> DataOut=0x3C, no error flags.
